// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Data-memory port sequencer for the M stage of the 5-stage RISC-V pipeline.
// Converts an M-stage load/store into a req/ack transaction on a
// variable-latency bus and stalls the pipeline until the access completes.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_mem_en_M/i_mem_wr_M  M-stage memory op valid / store (1) or load (0)
//   i_slt_sl_M            size/sign select (pipeline encoding)
//   i_addr_M, i_wdata_M   byte address and store data
//   i_flush_M             kill the M-stage instruction
//   o_bus_req/we/sel/addr/wdata   registered bus request side
//   i_bus_ack/err/rdata   bus completion, error (valid with ack), read data
//   o_stall_M             combinational stall to the hazard unit
//   o_rdata_M             registered load data for the W-stage mux
//   o_fault_M             one-cycle fault pulse in the completion cycle
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a request that sees no
// ack within TIMEOUT_CYCLES cycles. Without it REQ waits for ack forever.

module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_en_M,
    input  logic        i_mem_wr_M,
    input  logic [2:0]  i_slt_sl_M,
    input  logic [31:0] i_addr_M,
    input  logic [31:0] i_wdata_M,
    input  logic        i_flush_M,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [2:0]  o_bus_sel,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall_M,
    output logic [31:0] o_rdata_M,
    output logic        o_fault_M
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e state_q;
    // Set by a flush seen while the transaction is in flight; suppresses the fault.
    logic   kill_q;

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    // Fires on the cycle the counter would reach TIMEOUT_CYCLES, so the request
    // is held for exactly TIMEOUT_CYCLES cycles.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (CNT_W == 0) ^ (TIMEOUT_CYCLES == 0);
`endif

    assign o_stall_M = i_rst_n &&
                       (((state_q == StIdle) && i_mem_en_M && !i_flush_M) ||
                        (state_q == StReq));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            kill_q      <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_sel   <= 3'b000;
            o_bus_addr  <= 32'h0;
            o_bus_wdata <= 32'h0;
            o_rdata_M   <= 32'h0;
            o_fault_M   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    o_fault_M <= 1'b0;
                    if (i_mem_en_M && !i_flush_M) begin
                        o_bus_addr  <= i_addr_M;
                        o_bus_wdata <= i_wdata_M;
                        o_bus_we    <= i_mem_wr_M;
                        o_bus_sel   <= i_slt_sl_M;
                        o_bus_req   <= 1'b1;
                        kill_q      <= 1'b0;
                        state_q     <= StReq;
`ifdef DMEM_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                StReq: begin
                    if (i_flush_M) begin
                        kill_q <= 1'b1;
                    end
`ifdef DMEM_TIMEOUT_EN
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        state_q   <= StDone;
                        o_fault_M <= i_bus_err && !kill_q && !i_flush_M;
                        if (!o_bus_we) begin
                            o_rdata_M <= i_bus_rdata;
                        end
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (timeout) begin
                        o_bus_req <= 1'b0;
                        state_q   <= StDone;
                        o_fault_M <= !kill_q && !i_flush_M;
                    end
`endif
                end
                StDone: begin
                    o_fault_M <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    o_bus_req <= 1'b0;
                    o_fault_M <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
